// File: rtl/accel_pkg.sv
// Shared types and helpers for the accelerometer sample scheduler.
package accel_pkg;

    localparam int AXIS_W = 16;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        REQ       = 3'd2,
        BUSY      = 3'd3,
        ACCUM     = 3'd4
    } sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/axis_accumulator.sv
// One axis of the box-car averager: sign-extends each sample into a running
// sum and yields the floor-divided block average when the block closes.
module axis_accumulator
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add,
    input  logic              last,
    input  logic              clr,
    input  logic [AXIS_W-1:0] sample,
    output logic [AXIS_W-1:0] result
);
    localparam int ACC_W = AXIS_W + AVG_LOG2;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sum_s;

    assign sum_s  = acc_r + ACC_W'(signed'(sample));
    assign result = AXIS_W'(sum_s >>> AVG_LOG2);

    // Running sum; the closing sample of a block restarts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (add) begin
            acc_r <= last ? '0 : sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/accel_sample_scheduler.sv
// Periodically fetches X/Y/Z from the ADXL345 controller, averages blocks of
// 2^AVG_LOG2 samples and offers each average on a valid/ready stream.
module accel_sample_scheduler
    import accel_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 50000,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              adxl_busy,
    input  logic [AXIS_W-1:0] adxl_x,
    input  logic [AXIS_W-1:0] adxl_y,
    input  logic [AXIS_W-1:0] adxl_z,
    output logic              adxl_fetch,
    output logic [AXIS_W-1:0] out_x,
    output logic [AXIS_W-1:0] out_y,
    output logic [AXIS_W-1:0] out_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        overrun_count,
    output logic              timeout_err
);
    localparam int PER_W = $clog2(PERIOD_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    sched_state_t      state_r;
    logic [PER_W-1:0]  period_r;
    logic [TMO_W-1:0]  tmo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              tick_pend_r;
    logic              discard_r;
    logic              enable_d_r;
    logic [AXIS_W-1:0] cap_x_r, cap_y_r, cap_z_r;
    logic [AXIS_W-1:0] res_x_s, res_y_s, res_z_s;
    logic              tick_s, go_req_s, acc_add_s, acc_last_s, acc_clr_s, load_s;

    // Tick, request and accumulate controls; a tick may start a request directly.
    always_comb begin
        tick_s     = enable && (period_r == PER_LAST);
        go_req_s   = (state_r == IDLE) && enable && (tick_pend_r || tick_s);
        acc_add_s  = (state_r == ACCUM) && enable && !discard_r;
        acc_last_s = (cnt_r == CNT_LAST);
        load_s     = acc_add_s && acc_last_s;
        acc_clr_s  = !enable && ((state_r == IDLE) || (state_r == ACCUM) ||
                                 ((state_r == WAIT_INIT) && !adxl_busy));
    end

    // Sample-rate period counter and the single-entry pending tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r    <= '0;
            tick_pend_r <= 1'b0;
        end else if (!enable) begin
            period_r    <= '0;
            tick_pend_r <= 1'b0;
        end else begin
            period_r    <= tick_s ? '0 : period_r + PER_W'(1);
            tick_pend_r <= go_req_s ? 1'b0 : (tick_pend_r | tick_s);
        end
    end

    // Sequencer: fetch handshake, axis capture, timeout abort and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= WAIT_INIT;
            adxl_fetch  <= 1'b0;
            tmo_r       <= '0;
            discard_r   <= 1'b0;
            enable_d_r  <= 1'b0;
            timeout_err <= 1'b0;
            cap_x_r     <= '0;
            cap_y_r     <= '0;
            cap_z_r     <= '0;
        end else begin
            enable_d_r <= enable;
            if (enable && !enable_d_r) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end
            case (state_r)
                WAIT_INIT: begin
                    adxl_fetch <= 1'b0;
                    state_r    <= adxl_busy ? WAIT_INIT : IDLE;
                end
                IDLE: begin
                    if (go_req_s) begin
                        state_r    <= REQ;
                        adxl_fetch <= 1'b1;
                        tmo_r      <= '0;
                        discard_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ, BUSY: begin
                    // Disabling mid-transfer lets it finish but drops its result.
                    if (!enable) begin
                        discard_r <= 1'b1;
                    end
                    if (tmo_r == TMO_LAST) begin
                        state_r     <= WAIT_INIT;
                        adxl_fetch  <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if ((state_r == REQ) && adxl_busy) begin
                        state_r    <= BUSY;
                        adxl_fetch <= 1'b0;
                        tmo_r      <= tmo_r + TMO_W'(1);
                    end else if ((state_r == BUSY) && !adxl_busy) begin
                        state_r <= ACCUM;
                        cap_x_r <= adxl_x;
                        cap_y_r <= adxl_y;
                        cap_z_r <= adxl_z;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ACCUM: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= WAIT_INIT;
                    adxl_fetch <= 1'b0;
                end
            endcase
        end
    end

    // Samples accumulated in the current block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (acc_clr_s || load_s) begin
            cnt_r <= '0;
        end else if (acc_add_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_x (
        .clk(clk), .rst_n(rst_n), .add(acc_add_s), .last(acc_last_s),
        .clr(acc_clr_s), .sample(cap_x_r), .result(res_x_s)
    );
    axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_y (
        .clk(clk), .rst_n(rst_n), .add(acc_add_s), .last(acc_last_s),
        .clr(acc_clr_s), .sample(cap_y_r), .result(res_y_s)
    );
    axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_z (
        .clk(clk), .rst_n(rst_n), .add(acc_add_s), .last(acc_last_s),
        .clr(acc_clr_s), .sample(cap_z_r), .result(res_z_s)
    );

    // Output stream register: a load always wins, overwriting unread data counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x         <= '0;
            out_y         <= '0;
            out_z         <= '0;
            out_valid     <= 1'b0;
            overrun_count <= 8'd0;
        end else if (load_s) begin
            out_x     <= res_x_s;
            out_y     <= res_y_s;
            out_z     <= res_z_s;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun_count <= sat_inc8(overrun_count);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_accel_sample_scheduler.sv
// Bench for accel_sample_scheduler: randomised controller responses checked
// against a floor-average reference model, plus directed corner scenarios.
module tb_accel_sample_scheduler;
    import accel_pkg::*;

    localparam int PERIOD = 100;
    localparam int TMO    = 4096;

    logic        clk = 1'b0;
    logic        rst_n, enable, adxl_busy, out_ready;
    logic        ready0 = 1'b1;
    logic [15:0] adxl_x, adxl_y, adxl_z;
    logic        adxl_fetch, out_valid, timeout_err;
    logic [15:0] out_x, out_y, out_z;
    logic [7:0]  overrun_count;
    logic        fetch0, out0_valid, terr0;
    logic [15:0] out0_x, out0_y, out0_z;
    logic [7:0]  ovr0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model and controller-model state
    bit          model_en = 1'b1, mon_en = 1'b1, ctl_hold = 1'b1, ctl_respond = 1'b1;
    bit          ready_same_edge = 1'b0, avg_pend = 1'b0;
    int          deliv = 0, m_cnt = 0, m_sx = 0, m_sy = 0, m_sz = 0;
    int          hs_cnt = 0, p_cnt = 0;
    logic [15:0] m_ex, m_ey, m_ez, last_x, last_y, last_z, last0_x;
    logic [47:0] smp_q[$];
    logic [47:0] exp0_q[$];
    int          exp0_cyc_q[$];

    accel_sample_scheduler #(.PERIOD_CYCLES(PERIOD), .AVG_LOG2(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adxl_busy(adxl_busy),
        .adxl_x(adxl_x), .adxl_y(adxl_y), .adxl_z(adxl_z), .adxl_fetch(adxl_fetch),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_valid(out_valid),
        .out_ready(out_ready), .overrun_count(overrun_count), .timeout_err(timeout_err)
    );

    accel_sample_scheduler #(.PERIOD_CYCLES(PERIOD), .AVG_LOG2(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adxl_busy(adxl_busy),
        .adxl_x(adxl_x), .adxl_y(adxl_y), .adxl_z(adxl_z), .adxl_fetch(fetch0),
        .out_x(out0_x), .out_y(out0_y), .out_z(out0_z), .out_valid(out0_valid),
        .out_ready(ready0), .overrun_count(ovr0), .timeout_err(terr0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int floor_div4(input int s);
        floor_div4 = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    endfunction

    task automatic model_push(input logic [47:0] s);
        m_sx = m_sx + int'($signed(s[47:32]));
        m_sy = m_sy + int'($signed(s[31:16]));
        m_sz = m_sz + int'($signed(s[15:0]));
        m_cnt++;
        exp0_q.push_back(s);
        exp0_cyc_q.push_back(cyc);
        if (m_cnt == 4) begin
            m_ex = 16'(floor_div4(m_sx));
            m_ey = 16'(floor_div4(m_sy));
            m_ez = 16'(floor_div4(m_sz));
            m_sx = 0; m_sy = 0; m_sz = 0; m_cnt = 0;
            avg_pend = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_sz = 0; m_cnt = 0;
        avg_pend = 1'b0;
        exp0_q.delete();
        exp0_cyc_q.delete();
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int target = deliv + n;
        int budget = n * PERIOD * 2 + 200;
        while (deliv < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_deliv_reached"}, 32'(deliv >= target), 32'd1);
    endtask

    // Controller model: answers each fetch after a random delay and busy time
    initial begin
        logic [47:0] s;
        adxl_busy = 1'b1;
        adxl_x = 16'd0; adxl_y = 16'd0; adxl_z = 16'd0;
        forever begin
            @(negedge clk);
            if (ctl_hold) begin
                adxl_busy = 1'b1;
            end else if (ctl_respond && adxl_fetch) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                adxl_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (smp_q.size() != 0) s = smp_q.pop_front();
                else s = {16'($urandom), 16'($urandom), 16'($urandom)};
                {adxl_x, adxl_y, adxl_z} = s;
                adxl_busy = 1'b0;
                if (model_en && rst_n && !ctl_hold) begin
                    deliv++;
                    model_push(s);
                    if (ready_same_edge && m_cnt == 0) begin
                        @(negedge clk);
                        out_ready = 1'b1;
                        @(negedge clk);
                        check("same_edge_valid", 32'(out_valid), 32'd1);
                        check("same_edge_overrun", 32'(overrun_count), 32'd2);
                        check("same_edge_x", 32'(out_x), 32'(m_ex));
                        ready_same_edge = 1'b0;
                    end
                end
            end else begin
                adxl_busy = 1'b0;
            end
        end
    end

    // Stream monitors: averaged output on handshake, passthrough every valid cycle
    initial begin
        logic [47:0] e0;
        int          ec;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (out_valid && out_ready) begin
                    check("avg_x", 32'(out_x), avg_pend ? 32'(m_ex) : 32'hxxxx);
                    check("avg_y", 32'(out_y), avg_pend ? 32'(m_ey) : 32'hxxxx);
                    check("avg_z", 32'(out_z), avg_pend ? 32'(m_ez) : 32'hxxxx);
                    avg_pend = 1'b0;
                    hs_cnt++;
                    last_x = out_x; last_y = out_y; last_z = out_z;
                end
                if (out0_valid) begin
                    e0 = (exp0_q.size() != 0) ? exp0_q.pop_front() : 48'hx;
                    ec = (exp0_cyc_q.size() != 0) ? exp0_cyc_q.pop_front() + 2 : -1;
                    check("pass_xyz", 32'({out0_x, out0_y, out0_z} === e0), 32'd1);
                    check("pass_latency", 32'(cyc), 32'(ec));
                    last0_x = out0_x;
                    p_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n, hs0;
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
        smp_q.push_back({16'd4,  16'hFFFF, 16'h7FFF});
        smp_q.push_back({16'd8,  16'hFFFF, 16'h7FFF});
        smp_q.push_back({16'd12, 16'hFFFF, 16'h7FFF});
        smp_q.push_back({16'd16, 16'hFFFE, 16'h7FFF});
        smp_q.push_back({16'h8000, 16'h0001, 16'hFFFF});
        repeat (3) @(negedge clk);
        check("rst_fetch", 32'(adxl_fetch), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'({out_x, out_y, out_z} == 48'd0), 32'd1);
        check("rst_overrun", 32'(overrun_count), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // Start-up: busy held for 50 cycles; first fetch right after the first tick
        rst_n = 1'b1; enable = 1'b1;
        for (int k = 1; k <= PERIOD; k++) begin
            if (k == 50) ctl_hold = 1'b0;
            @(negedge clk);
            if (k == 49) check("startup_wait_init", 32'(dut.state_r), 32'(WAIT_INIT));
            if (k >= 98) check($sformatf("startup_fetch_k%0d", k), 32'(adxl_fetch), 32'(k == PERIOD));
        end

        // Directed average, then passthrough of 0x8000 and random blocks
        wait_deliv(3, "avg3");
        repeat (3) @(negedge clk);
        check("no_avg_after_3", 32'(hs_cnt), 32'd0);
        wait_deliv(1, "avg4");
        repeat (3) @(negedge clk);
        check("avg_count_1", 32'(hs_cnt), 32'd1);
        check("avg_dir_x", 32'(last_x), 32'd10);
        check("avg_dir_y", 32'(last_y), 32'hFFFE);
        check("avg_dir_z", 32'(last_z), 32'h7FFF);
        wait_deliv(1, "pass8000");
        repeat (3) @(negedge clk);
        check("pass_8000", 32'(last0_x), 32'h8000);
        wait_deliv(7, "rand");
        repeat (4) @(negedge clk);
        check("avg_count_3", 32'(hs_cnt), 32'd3);
        check("pass_count", 32'(p_cnt), 32'(deliv));

        // Backpressure across three averages, then load and ready on one edge
        mon_en = 1'b0; out_ready = 1'b0;
        wait_deliv(12, "bp");
        repeat (3) @(negedge clk);
        check("bp_overrun", 32'(overrun_count), 32'd2);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_latest", 32'({out_x, out_y, out_z} === {m_ex, m_ey, m_ez}), 32'd1);
        ready_same_edge = 1'b1;
        wait_deliv(4, "same_edge");
        repeat (4) @(negedge clk);
        check("same_edge_overrun_after", 32'(overrun_count), 32'd2);
        check("same_edge_drained", 32'(out_valid), 32'd0);
        model_clear();
        mon_en = 1'b1;

        // Timeout: controller ignores fetch
        model_en = 1'b0; mon_en = 1'b0; ctl_respond = 1'b0;
        check("tmo_err_before", 32'(timeout_err), 32'd0);
        b = 300;
        while (!adxl_fetch && b > 0) begin @(negedge clk); b--; end
        n = 0;
        while (adxl_fetch && n < TMO + 10) begin n++; @(negedge clk); end
        check("tmo_len", 32'(n), 32'(TMO));
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_fetch", 32'(adxl_fetch), 32'd0);
        check("tmo_state", 32'(dut.state_r), 32'(WAIT_INIT));
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_err_held", 32'(timeout_err), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        check("tmo_err_cleared", 32'(timeout_err), 32'd0);

        // Asynchronous reset while in BUSY
        ctl_respond = 1'b1;
        b = 300;
        while (!adxl_busy && b > 0) begin @(negedge clk); b--; end
        @(negedge clk);
        check("mid_busy_state", 32'(dut.state_r), 32'(BUSY));
        #2 rst_n = 1'b0;
        #1;
        check("async_fetch", 32'(adxl_fetch), 32'd0);
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_out", 32'({out_x, out_y, out_z} == 48'd0), 32'd1);
        check("async_overrun", 32'(overrun_count), 32'd0);
        check("async_state", 32'(dut.state_r), 32'(WAIT_INIT));
        ctl_hold = 1'b1;
        repeat (10) @(negedge clk);
        model_clear();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k % 5 == 0) begin
                check($sformatf("post_rst_wait_k%0d", k), 32'(dut.state_r), 32'(WAIT_INIT));
                check($sformatf("post_rst_fetch_k%0d", k), 32'(adxl_fetch), 32'd0);
            end
        end
        ctl_hold = 1'b0; model_en = 1'b1; mon_en = 1'b1;
        hs0 = hs_cnt;
        wait_deliv(8, "post_rst");
        repeat (4) @(negedge clk);
        check("post_rst_avgs", 32'(hs_cnt), 32'(hs0 + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
